// File: rtl/gbsha_ttfir_pkg.sv
// rtl/gbsha_ttfir_pkg.sv - shared types and helpers for the sequential FIR
// Optional clamp to the output range is enabled by GBSHA_TTFIR_SAT_EN.
package gbsha_ttfir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Accumulator wide enough that N_TAPS full-scale products never overflow.
    function automatic int acc_width(input int n_taps, input int bw_in);
        return 2 * bw_in + $clog2(n_taps);
    endfunction

    // Returns the value to emit, sign-extended to 64 bits; caller keeps bw_out LSBs.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] s,
                                                     input int                 bw_out);
`ifdef GBSHA_TTFIR_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw_out - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
`else
        return (s <<< (64 - bw_out)) >>> (64 - bw_out);
`endif
    endfunction

endpackage

// File: rtl/gbsha_ttfir_mac.sv
// rtl/gbsha_ttfir_mac.sv - time-multiplexed multiply-accumulate over the tap registers
module gbsha_ttfir_mac #(
    parameter int N_TAPS = 4,
    parameter int BW_in  = 6,
    parameter int BW_ACC = 14,
    parameter int KW     = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clr,
    input  logic                              en,
    input  logic [KW-1:0]                     k,
    input  logic [N_TAPS-1:0][BW_in-1:0]      coef,
    input  logic [N_TAPS-1:0][BW_in-1:0]      samp,
    output logic signed [BW_ACC-1:0]          acc
);

    logic signed [BW_in-1:0]    c_sel;
    logic signed [BW_in-1:0]    x_sel;
    logic signed [2*BW_in-1:0]  c_ext;
    logic signed [2*BW_in-1:0]  x_ext;
    logic signed [2*BW_in-1:0]  prod;
    logic signed [BW_ACC-1:0]   prod_ext;

    // Tap mux; out-of-range k (the drain cycle) selects zero operands.
    always_comb begin
        c_sel = '0;
        x_sel = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            if (k == KW'(i)) begin
                c_sel = coef[i];
                x_sel = samp[i];
            end
        end
    end

    assign c_ext    = {{BW_in{c_sel[BW_in-1]}}, c_sel};
    assign x_ext    = {{BW_in{x_sel[BW_in-1]}}, x_sel};
    assign prod     = c_ext * x_ext;
    assign prod_ext = {{(BW_ACC - 2*BW_in){prod[2*BW_in-1]}}, prod};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/gbsha_ttfir_seq.sv
// rtl/gbsha_ttfir_seq.sv - sequential N-tap FIR with valid/ready ports
// Define GBSHA_TTFIR_SAT_EN to clamp instead of wrapping the scaled output.
module gbsha_ttfir_seq
    import gbsha_ttfir_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int BW_in  = 6,
    parameter int BW_out = 8,
    parameter int SHIFT  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_load,
    input  logic signed [BW_in-1:0]  in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [BW_out-1:0] out_data
);

    localparam int BW_ACC = acc_width(N_TAPS, BW_in);
    localparam int KW     = $clog2(N_TAPS + 1);

    state_t                          state;
    state_t                          next_state;
    logic [N_TAPS-1:0][BW_in-1:0]    coef;
    logic [N_TAPS-1:0][BW_in-1:0]    samp;
    logic [KW-1:0]                   k;
    logic signed [BW_ACC-1:0]        acc;
    logic signed [BW_ACC-1:0]        s;
    logic signed [63:0]              s_ext;
    logic                            coef_ld;
    logic                            samp_ld;
    logic                            mac_clr;
    logic                            mac_en;
    logic                            out_ld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // k runs 0..N_TAPS-1 accumulating, then one extra cycle at k==N_TAPS latches the result.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        coef_ld    = 1'b0;
        samp_ld    = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        out_ld     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_load) begin
                        coef_ld = 1'b1;
                    end else begin
                        samp_ld    = 1'b1;
                        mac_clr    = 1'b1;
                        next_state = MAC;
                    end
                end
            end
            MAC: begin
                if (k == KW'(N_TAPS)) begin
                    out_ld     = 1'b1;
                    next_state = OUT;
                end else begin
                    mac_en = 1'b1;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef <= '0;
            samp <= '0;
            k    <= '0;
        end else begin
            if (coef_ld) begin
                coef <= {coef[N_TAPS-2:0], in_data};
            end
            if (samp_ld) begin
                samp <= {samp[N_TAPS-2:0], in_data};
                k    <= '0;
            end else if (mac_en) begin
                k <= k + KW'(1);
            end
        end
    end

    gbsha_ttfir_mac #(
        .N_TAPS (N_TAPS),
        .BW_in  (BW_in),
        .BW_ACC (BW_ACC),
        .KW     (KW)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .k     (k),
        .coef  (coef),
        .samp  (samp),
        .acc   (acc)
    );

    assign s     = acc >>> SHIFT;
    assign s_ext = {{(64 - BW_ACC){s[BW_ACC-1]}}, s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
        end else if (out_ld) begin
            out_data <= BW_out'(sat_trunc(s_ext, BW_out));
        end
    end

endmodule

// File: tb/tb_gbsha_ttfir_seq.sv
// tb/tb_gbsha_ttfir_seq.sv - directed self-checking bench for gbsha_ttfir_seq
module tb_gbsha_ttfir_seq;

`ifdef GBSHA_TTFIR_SAT_EN
    localparam int SAT_EXP = 127;
`else
    localparam int SAT_EXP = -128;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_load;
    logic signed [5:0]      in_data;
    logic                   out_ready;
    logic [2:0]             rdy;
    logic [2:0]             ov;
    logic signed [7:0]      od [3];
    int                     n_checks = 0;
    int                     n_errors = 0;
    logic signed [7:0]      res;

    always #5 clk = ~clk;

    // 0: default (N=4, SHIFT=5); 1: N=4, SHIFT=0; 2: N=8, SHIFT=0
    gbsha_ttfir_seq u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_load(in_load), .in_data(in_data),
        .in_ready(rdy[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0])
    );
    gbsha_ttfir_seq #(.SHIFT(0)) u_s0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_load(in_load), .in_data(in_data),
        .in_ready(rdy[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1])
    );
    gbsha_ttfir_seq #(.N_TAPS(8), .SHIFT(0)) u_n8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_load(in_load), .in_data(in_data),
        .in_ready(rdy[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2])
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic wait_rdy(input int sel);
        int n = 0;
        while (rdy[sel] !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(rdy[sel]), 1);
    endtask

    task automatic put(input int sel, input logic load, input int val);
        wait_rdy(sel);
        in_valid = 1'b1;
        in_load  = load;
        in_data  = 6'(val);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic sample(input int sel, input int val, input int lat,
                          output logic signed [7:0] r);
        int n = 0;
        put(sel, 1'b0, val);
        while (ov[sel] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, lat);
        r = od[sel];
    endtask

    task automatic run(input string tag, input int sel, input int val, input int lat,
                       input int exp);
        logic signed [7:0] r;
        sample(sel, val, lat, r);
        check(tag, r, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_load   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("rst_out_valid", 32'(ov[0]), 0);
        check("rst_out_data", od[0], 0);
        check("rst_in_ready", 32'(rdy[0]), 1);

        // impulse, N=4, SHIFT=0
        do_reset();
        for (int i = 1; i <= 4; i++) put(1, 1'b1, i);
        run("imp4_0", 1, 1, 5, 4);
        run("imp4_1", 1, 0, 5, 3);
        run("imp4_2", 1, 0, 5, 2);
        run("imp4_3", 1, 0, 5, 1);
        run("imp4_4", 1, 0, 5, 0);

        // impulse, N=8, SHIFT=0
        do_reset();
        for (int i = 1; i <= 8; i++) put(2, 1'b1, i);
        run("imp8_0", 2, 1, 9, 8);
        for (int i = 1; i < 8; i++) run("imp8_n", 2, 0, 9, 8 - i);

        // latency and backpressure: 31*31=961, >>>5 = 30
        do_reset();
        put(0, 1'b1, 31);
        out_ready = 1'b0;
        sample(0, 31, 5, res);
        check("bp_first", res, 30);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(ov[0]), 1);
            check("bp_data", od[0], 30);
            check("bp_in_ready", 32'(rdy[0]), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_valid_drop", 32'(ov[0]), 0);
        check("hs_in_ready", 32'(rdy[0]), 1);

        // saturation: acc grows by 1024 per filled tap
        do_reset();
        for (int i = 0; i < 4; i++) put(0, 1'b1, -32);
        run("sat_1", 0, -32, 5, 32);
        run("sat_2", 0, -32, 5, 64);
        run("sat_3", 0, -32, 5, 96);
        run("sat_4", 0, -32, 5, SAT_EXP);

        // floor scaling
        do_reset();
        put(0, 1'b1, -1);
        run("floor_m1", 0, 1, 5, -1);
        run("floor_m31", 0, 31, 5, -1);
        do_reset();
        put(0, 1'b1, 1);
        run("floor_p31", 0, 31, 5, 0);

        // async reset in the middle of a MAC
        do_reset();
        put(0, 1'b1, 31);
        run("pre_abort", 0, 31, 5, 30);
        put(0, 1'b0, 31);
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        check("abort_valid", 32'(ov[0]), 0);
        check("abort_data", od[0], 0);
        check("abort_in_ready", 32'(rdy[0]), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ov[0] === 1'b1) cnt++;
        end
        check("abort_no_pulse", cnt, 0);
        run("abort_after", 0, 1, 5, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
